// File: rtl/ps2_bbc_keyboard_matrix_pkg.sv
// ---------------------------------------------------------------------------
// ps2_bbc_keyboard_matrix_pkg
// Shared types and constants for the PS/2 (scancode set 2) to BBC micro
// keyboard matrix converter.
//   t_bbc_keyboard   : keyboard state bundle handed to the matrix scan logic
//   t_ps2_rx_data    : one received PS/2 byte with its strobe and error flag
//   t_key_map_entry  : result of the {ext, code} -> matrix position lookup
//   t_state          : prefix tracking states of the byte-stream decoder
// ---------------------------------------------------------------------------
package ps2_bbc_keyboard_matrix_pkg;

    localparam int NUM_COLS = 10;
    localparam int NUM_ROWS = 8;
    localparam int NUM_KEYS = NUM_COLS * NUM_ROWS;

    // Scancode set 2 control bytes
    localparam logic [7:0] SC_E0         = 8'hE0;
    localparam logic [7:0] SC_E1         = 8'hE1;
    localparam logic [7:0] SC_F0         = 8'hF0;
    localparam logic [7:0] SC_AA         = 8'hAA;
    localparam logic [7:0] SC_FAKE_SHIFT = 8'h12;  // E0 12: fake shift
    localparam logic [7:0] SC_FAKE_PRTSC = 8'h7C;  // E0 7C: PrtSc half

    // Bytes that follow the leading E1 of the Pause make sequence
    localparam logic [2:0] E1_SKIP_BYTES = 3'd7;

    typedef struct packed {
        logic        reset_pressed;
        logic [63:0] keys_down_cols_0_to_7;
        logic [15:0] keys_down_cols_8_to_9;
    } t_bbc_keyboard;

    typedef struct packed {
        logic       valid;
        logic [7:0] data;
        logic       error;
    } t_ps2_rx_data;

    typedef struct packed {
        logic       mapped;
        logic       is_break_key;
        logic [3:0] column;
        logic [2:0] row;
    } t_key_map_entry;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GOT_E0,
        ST_GOT_F0,
        ST_GOT_E0_F0,
        ST_SKIP_E1
    } t_state;

    // Ordinary matrix key at (column, row)
    function automatic t_key_map_entry key_at(input logic [3:0] column,
                                              input logic [2:0] row);
        t_key_map_entry e;
        e.mapped       = 1'b1;
        e.is_break_key = 1'b0;
        e.column       = column;
        e.row          = row;
        return e;
    endfunction

    // Keyboard-to-host protocol bytes that carry no key information
    function automatic logic is_ignored_code(input logic [7:0] code);
        return (code == 8'h00) || (code == 8'hFA) || (code == 8'hFC) ||
               (code == 8'hFE) || (code == 8'hFF);
    endfunction

endpackage

// File: rtl/ps2_bbc_keyboard_matrix_key_map.sv
// ---------------------------------------------------------------------------
// ps2_bbc_key_map
// Combinational lookup from a completed PS/2 set 2 key ({ext, code}) to a
// BBC micro keyboard matrix position.
//   ext   : code was preceded by E0
//   code  : scancode byte
//   entry : {mapped, is_break_key, column, row}; all zero when unmapped
// Keypad digits and symbols alias onto the main keyboard keys. Row 0 of
// columns 2-9 carries the DIP links and is never targeted here.
// ---------------------------------------------------------------------------
module ps2_bbc_key_map
    import ps2_bbc_keyboard_matrix_pkg::*;
(
    input  logic           ext,
    input  logic [7:0]     code,
    output t_key_map_entry entry
);

    always_comb begin
        entry = '0;
        case ({ext, code})
            // row 0: shift (both), ctrl (both)
            9'h012, 9'h059: entry = key_at(4'd0, 3'd0);
            9'h014, 9'h114: entry = key_at(4'd1, 3'd0);
            // row 1
            9'h015: entry = key_at(4'd0, 3'd1);  // Q
            9'h026: entry = key_at(4'd1, 3'd1);  // 3
            9'h025: entry = key_at(4'd2, 3'd1);  // 4
            9'h02E: entry = key_at(4'd3, 3'd1);  // 5
            9'h00C: entry = key_at(4'd4, 3'd1);  // f4
            9'h03E: entry = key_at(4'd5, 3'd1);  // 8
            9'h083: entry = key_at(4'd6, 3'd1);  // f7
            9'h04E: entry = key_at(4'd7, 3'd1);  // -
            9'h055: entry = key_at(4'd8, 3'd1);  // ^ on =
            9'h16B: entry = key_at(4'd9, 3'd1);  // left arrow
            // row 2
            9'h009: entry = key_at(4'd0, 3'd2);  // f0 on F10
            9'h01D: entry = key_at(4'd1, 3'd2);  // W
            9'h024: entry = key_at(4'd2, 3'd2);  // E
            9'h02C: entry = key_at(4'd3, 3'd2);  // T
            9'h03D: entry = key_at(4'd4, 3'd2);  // 7
            9'h043: entry = key_at(4'd5, 3'd2);  // I
            9'h046: entry = key_at(4'd6, 3'd2);  // 9
            9'h045: entry = key_at(4'd7, 3'd2);  // 0
            9'h061: entry = key_at(4'd8, 3'd2);  // _ on ISO backslash
            9'h172: entry = key_at(4'd9, 3'd2);  // down arrow
            // row 3
            9'h016: entry = key_at(4'd0, 3'd3);  // 1
            9'h01E: entry = key_at(4'd1, 3'd3);  // 2
            9'h023: entry = key_at(4'd2, 3'd3);  // D
            9'h02D: entry = key_at(4'd3, 3'd3);  // R
            9'h036: entry = key_at(4'd4, 3'd3);  // 6
            9'h03C: entry = key_at(4'd5, 3'd3);  // U
            9'h044: entry = key_at(4'd6, 3'd3);  // O
            9'h04D: entry = key_at(4'd7, 3'd3);  // P
            9'h054: entry = key_at(4'd8, 3'd3);  // [
            9'h175: entry = key_at(4'd9, 3'd3);  // up arrow
            // row 4
            9'h058: entry = key_at(4'd0, 3'd4);  // caps lock
            9'h01C: entry = key_at(4'd1, 3'd4);  // A
            9'h022: entry = key_at(4'd2, 3'd4);  // X
            9'h02B: entry = key_at(4'd3, 3'd4);  // F
            9'h035: entry = key_at(4'd4, 3'd4);  // Y
            9'h03B: entry = key_at(4'd5, 3'd4);  // J
            9'h042: entry = key_at(4'd6, 3'd4);  // K
            9'h00E: entry = key_at(4'd7, 3'd4);  // @ on backtick
            9'h052: entry = key_at(4'd8, 3'd4);  // : on quote
            9'h05A, 9'h15A: entry = key_at(4'd9, 3'd4);  // return, kp enter
            // row 5
            9'h07E: entry = key_at(4'd0, 3'd5);  // shift lock on scroll lock
            9'h01B: entry = key_at(4'd1, 3'd5);  // S
            9'h021: entry = key_at(4'd2, 3'd5);  // C
            9'h034: entry = key_at(4'd3, 3'd5);  // G
            9'h033: entry = key_at(4'd4, 3'd5);  // H
            9'h031: entry = key_at(4'd5, 3'd5);  // N
            9'h04B: entry = key_at(4'd6, 3'd5);  // L
            9'h04C: entry = key_at(4'd7, 3'd5);  // ;
            9'h05B: entry = key_at(4'd8, 3'd5);  // ]
            9'h066, 9'h171: entry = key_at(4'd9, 3'd5);  // backspace, delete
            // row 6
            9'h00D: entry = key_at(4'd0, 3'd6);  // tab
            9'h01A: entry = key_at(4'd1, 3'd6);  // Z
            9'h029: entry = key_at(4'd2, 3'd6);  // space
            9'h02A: entry = key_at(4'd3, 3'd6);  // V
            9'h032: entry = key_at(4'd4, 3'd6);  // B
            9'h03A: entry = key_at(4'd5, 3'd6);  // M
            9'h041: entry = key_at(4'd6, 3'd6);  // ,
            9'h049: entry = key_at(4'd7, 3'd6);  // .
            9'h04A, 9'h14A: entry = key_at(4'd8, 3'd6);  // /, kp /
            9'h169: entry = key_at(4'd9, 3'd6);  // copy on End
            // row 7
            9'h076: entry = key_at(4'd0, 3'd7);  // escape
            9'h005: entry = key_at(4'd1, 3'd7);  // f1
            9'h006: entry = key_at(4'd2, 3'd7);  // f2
            9'h004: entry = key_at(4'd3, 3'd7);  // f3
            9'h003: entry = key_at(4'd4, 3'd7);  // f5
            9'h00B: entry = key_at(4'd5, 3'd7);  // f6
            9'h00A: entry = key_at(4'd6, 3'd7);  // f8
            9'h001: entry = key_at(4'd7, 3'd7);  // f9
            9'h05D: entry = key_at(4'd8, 3'd7);  // backslash
            9'h174: entry = key_at(4'd9, 3'd7);  // right arrow
            // keypad (num lock on) aliases onto the main keys
            9'h070: entry = key_at(4'd7, 3'd2);  // kp 0
            9'h069: entry = key_at(4'd0, 3'd3);  // kp 1
            9'h072: entry = key_at(4'd1, 3'd3);  // kp 2
            9'h07A: entry = key_at(4'd1, 3'd1);  // kp 3
            9'h06B: entry = key_at(4'd2, 3'd1);  // kp 4
            9'h073: entry = key_at(4'd3, 3'd1);  // kp 5
            9'h074: entry = key_at(4'd4, 3'd3);  // kp 6
            9'h06C: entry = key_at(4'd4, 3'd2);  // kp 7
            9'h075: entry = key_at(4'd5, 3'd1);  // kp 8
            9'h07D: entry = key_at(4'd6, 3'd2);  // kp 9
            9'h071: entry = key_at(4'd7, 3'd6);  // kp .
            9'h07B: entry = key_at(4'd7, 3'd1);  // kp -
            // F12 is the Break key: drives reset_pressed, not the matrix
            9'h007: begin
                entry.mapped       = 1'b1;
                entry.is_break_key = 1'b1;
            end
            default: entry = '0;
        endcase
    end

endmodule

// File: rtl/ps2_bbc_keyboard_matrix.sv
// ---------------------------------------------------------------------------
// ps2_bbc_keyboard_matrix
// Turns the received PS/2 set 2 byte stream into the BBC micro keyboard
// bundle: one held-down bit per matrix key plus the Break flag. Row 0 of
// columns 2-9 reports the (registered) DIP switches instead of keys.
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   ps2_rx__valid/data/error      : received byte strobe, byte, error flag
//   dip_switches                  : bit n -> column n+2 row 0
//   bbc_keyboard__reset_pressed   : Break key held
//   bbc_keyboard__keys_down_cols_0_to_7 : bit 8*c+r, columns 0-7
//   bbc_keyboard__keys_down_cols_8_to_9 : bit 8*(c-8)+r, columns 8-9
//   unmapped_key                  : one-cycle pulse, completed code unmapped
// Parameters:
//   prefix_timeout        : idle cycles tolerated inside a multi-byte code
//   release_all_on_error  : rx error or BAT (AA) releases every key
// ---------------------------------------------------------------------------
module ps2_bbc_keyboard_matrix
    import ps2_bbc_keyboard_matrix_pkg::*;
#(
    parameter int prefix_timeout       = 1000000,
    parameter bit release_all_on_error = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_rx__valid,
    input  logic [7:0]  ps2_rx__data,
    input  logic        ps2_rx__error,
    input  logic [7:0]  dip_switches,
    output logic        bbc_keyboard__reset_pressed,
    output logic [63:0] bbc_keyboard__keys_down_cols_0_to_7,
    output logic [15:0] bbc_keyboard__keys_down_cols_8_to_9,
    output logic        unmapped_key
);

    localparam int TMO_W = (prefix_timeout > 1) ? $clog2(prefix_timeout + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(prefix_timeout - 1);

    t_ps2_rx_data   rx;
    t_key_map_entry map_entry;
    t_bbc_keyboard  kb;

    t_state              state_reg, state_next;
    logic [2:0]          skip_reg, skip_next;
    logic [TMO_W-1:0]    tmo_reg, tmo_next;
    logic [NUM_KEYS-1:0] keys_reg, keys_next;
    logic                brk_reg, brk_next;
    logic                unmapped_reg, unmapped_next;
    logic [7:0]          dip_reg;

    logic                ext;
    logic                do_update;
    logic                do_make;
    logic                do_clear;
    logic [6:0]          key_index;

    logic [NUM_KEYS-1:0] dip_bits;
    logic [NUM_KEYS-1:0] dip_mask;
    logic [NUM_KEYS-1:0] keys_down;

    assign rx = '{valid: ps2_rx__valid, data: ps2_rx__data, error: ps2_rx__error};

    // The lookup always sees the byte in flight; ext comes from the prefix state.
    assign ext = (state_reg == ST_GOT_E0) || (state_reg == ST_GOT_E0_F0);

    ps2_bbc_key_map u_key_map (
        .ext   (ext),
        .code  (rx.data),
        .entry (map_entry)
    );

    // Matrix bit index 8*column + row
    assign key_index = {map_entry.column, map_entry.row};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            skip_reg     <= '0;
            tmo_reg      <= '0;
            keys_reg     <= '0;
            brk_reg      <= 1'b0;
            unmapped_reg <= 1'b0;
            dip_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            skip_reg     <= skip_next;
            tmo_reg      <= tmo_next;
            keys_reg     <= keys_next;
            brk_reg      <= brk_next;
            unmapped_reg <= unmapped_next;
            dip_reg      <= dip_switches;
        end
    end

    always_comb begin
        state_next    = state_reg;
        skip_next     = skip_reg;
        tmo_next      = '0;
        keys_next     = keys_reg;
        brk_next      = brk_reg;
        unmapped_next = 1'b0;
        do_update     = 1'b0;
        do_make       = 1'b0;
        do_clear      = 1'b0;

        if (rx.valid) begin
            if (rx.error) begin
                state_next = ST_IDLE;
                do_clear   = release_all_on_error;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (rx.data == SC_E0) begin
                            state_next = ST_GOT_E0;
                        end else if (rx.data == SC_F0) begin
                            state_next = ST_GOT_F0;
                        end else if (rx.data == SC_E1) begin
                            state_next = ST_SKIP_E1;
                            skip_next  = E1_SKIP_BYTES;
                        end else if (rx.data == SC_AA) begin
                            do_clear = release_all_on_error;
                        end else if (!is_ignored_code(rx.data)) begin
                            do_update = 1'b1;
                            do_make   = 1'b1;
                        end
                    end
                    ST_GOT_E0: begin
                        if (rx.data == SC_F0) begin
                            state_next = ST_GOT_E0_F0;
                        end else begin
                            state_next = ST_IDLE;
                            // Fake shift / PrtSc halves would otherwise
                            // toggle the real shift key.
                            if ((rx.data != SC_FAKE_SHIFT) && (rx.data != SC_FAKE_PRTSC)) begin
                                do_update = 1'b1;
                                do_make   = 1'b1;
                            end
                        end
                    end
                    ST_GOT_F0, ST_GOT_E0_F0: begin
                        state_next = ST_IDLE;
                        do_update  = 1'b1;
                    end
                    ST_SKIP_E1: begin
                        if (skip_reg <= 3'd1) begin
                            state_next = ST_IDLE;
                            skip_next  = '0;
                        end else begin
                            skip_next = skip_reg - 3'd1;
                        end
                    end
                    default: state_next = ST_IDLE;
                endcase
            end
        end else if (state_reg != ST_IDLE) begin
            // Abandon a half-received code after prefix_timeout idle cycles.
            if (tmo_reg >= TMO_LAST) begin
                state_next = ST_IDLE;
            end else begin
                tmo_next = tmo_reg + 1'b1;
            end
        end

        if (do_clear) begin
            keys_next = '0;
            brk_next  = 1'b0;
        end else if (do_update) begin
            if (!map_entry.mapped) begin
                unmapped_next = 1'b1;
            end else if (map_entry.is_break_key) begin
                brk_next = do_make;
            end else if (key_index < 7'(NUM_KEYS)) begin
                keys_next[key_index] = do_make;
            end
        end
    end

    // Row 0 of columns 2-9 shows the DIP links; elsewhere the stored key bits.
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_out_bit
        if (((gi % NUM_ROWS) == 0) && ((gi / NUM_ROWS) >= 2)) begin : g_dip
            assign dip_bits[gi] = dip_reg[(gi / NUM_ROWS) - 2];
            assign dip_mask[gi] = 1'b1;
        end else begin : g_key
            assign dip_bits[gi] = 1'b0;
            assign dip_mask[gi] = 1'b0;
        end
    end

    assign keys_down = (keys_reg & ~dip_mask) | dip_bits;

    assign kb = '{reset_pressed:         brk_reg,
                  keys_down_cols_0_to_7: keys_down[63:0],
                  keys_down_cols_8_to_9: keys_down[79:64]};

    assign bbc_keyboard__reset_pressed         = kb.reset_pressed;
    assign bbc_keyboard__keys_down_cols_0_to_7 = kb.keys_down_cols_0_to_7;
    assign bbc_keyboard__keys_down_cols_8_to_9 = kb.keys_down_cols_8_to_9;
    assign unmapped_key                        = unmapped_reg;

endmodule

// File: tb/tb_ps2_bbc_keyboard_matrix.sv
// ---------------------------------------------------------------------------
// tb_ps2_bbc_keyboard_matrix
// Directed scenarios followed by randomized PS/2 byte streams. The reference
// model keeps the bytes of the code in progress in a queue and decides from
// the queue contents when a code is complete; the key table is written as
// BBC internal key numbers (&rc = row r, column c).
// ---------------------------------------------------------------------------
module tb_ps2_bbc_keyboard_matrix;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        ps2_rx__valid;
    logic [7:0]  ps2_rx__data;
    logic        ps2_rx__error;
    logic [7:0]  dip_switches;
    logic        bbc_keyboard__reset_pressed;
    logic [63:0] bbc_keyboard__keys_down_cols_0_to_7;
    logic [15:0] bbc_keyboard__keys_down_cols_8_to_9;
    logic        unmapped_key;

    always #5 clk = ~clk;

    ps2_bbc_keyboard_matrix #(
        .prefix_timeout       (TMO),
        .release_all_on_error (1'b1)
    ) dut (
        .clk                                 (clk),
        .reset                               (reset),
        .ps2_rx__valid                       (ps2_rx__valid),
        .ps2_rx__data                        (ps2_rx__data),
        .ps2_rx__error                       (ps2_rx__error),
        .dip_switches                        (dip_switches),
        .bbc_keyboard__reset_pressed         (bbc_keyboard__reset_pressed),
        .bbc_keyboard__keys_down_cols_0_to_7 (bbc_keyboard__keys_down_cols_0_to_7),
        .bbc_keyboard__keys_down_cols_8_to_9 (bbc_keyboard__keys_down_cols_8_to_9),
        .unmapped_key                        (unmapped_key)
    );

    // ---------------- reference model ----------------
    int         key_bit[int];      // {ext,code} -> matrix bit index
    int         pool[$];           // mapped codes for random stimulus
    bit [79:0]  m_keys;
    bit         m_brk;
    bit         m_unm;
    logic [7:0] m_pending[$];
    int         m_gap;
    logic [7:0] m_dip;

    int n_cmp = 0;
    int n_bad = 0;
    int n_txn = 0;

    function automatic void add_key(input int sc, input logic [7:0] bbc_num);
        key_bit[sc] = int'(bbc_num[3:0]) * 8 + int'(bbc_num[7:4]);
        pool.push_back(sc);
    endfunction

    function automatic void build_table();
        add_key(9'h012, 8'h00); add_key(9'h059, 8'h00); add_key(9'h014, 8'h01); add_key(9'h114, 8'h01);
        add_key(9'h015, 8'h10); add_key(9'h026, 8'h11); add_key(9'h025, 8'h12); add_key(9'h02E, 8'h13);
        add_key(9'h00C, 8'h14); add_key(9'h03E, 8'h15); add_key(9'h083, 8'h16); add_key(9'h04E, 8'h17);
        add_key(9'h055, 8'h18); add_key(9'h16B, 8'h19);
        add_key(9'h009, 8'h20); add_key(9'h01D, 8'h21); add_key(9'h024, 8'h22); add_key(9'h02C, 8'h23);
        add_key(9'h03D, 8'h24); add_key(9'h043, 8'h25); add_key(9'h046, 8'h26); add_key(9'h045, 8'h27);
        add_key(9'h061, 8'h28); add_key(9'h172, 8'h29);
        add_key(9'h016, 8'h30); add_key(9'h01E, 8'h31); add_key(9'h023, 8'h32); add_key(9'h02D, 8'h33);
        add_key(9'h036, 8'h34); add_key(9'h03C, 8'h35); add_key(9'h044, 8'h36); add_key(9'h04D, 8'h37);
        add_key(9'h054, 8'h38); add_key(9'h175, 8'h39);
        add_key(9'h058, 8'h40); add_key(9'h01C, 8'h41); add_key(9'h022, 8'h42); add_key(9'h02B, 8'h43);
        add_key(9'h035, 8'h44); add_key(9'h03B, 8'h45); add_key(9'h042, 8'h46); add_key(9'h00E, 8'h47);
        add_key(9'h052, 8'h48); add_key(9'h05A, 8'h49); add_key(9'h15A, 8'h49);
        add_key(9'h07E, 8'h50); add_key(9'h01B, 8'h51); add_key(9'h021, 8'h52); add_key(9'h034, 8'h53);
        add_key(9'h033, 8'h54); add_key(9'h031, 8'h55); add_key(9'h04B, 8'h56); add_key(9'h04C, 8'h57);
        add_key(9'h05B, 8'h58); add_key(9'h066, 8'h59); add_key(9'h171, 8'h59);
        add_key(9'h00D, 8'h60); add_key(9'h01A, 8'h61); add_key(9'h029, 8'h62); add_key(9'h02A, 8'h63);
        add_key(9'h032, 8'h64); add_key(9'h03A, 8'h65); add_key(9'h041, 8'h66); add_key(9'h049, 8'h67);
        add_key(9'h04A, 8'h68); add_key(9'h14A, 8'h68); add_key(9'h169, 8'h69);
        add_key(9'h076, 8'h70); add_key(9'h005, 8'h71); add_key(9'h006, 8'h72); add_key(9'h004, 8'h73);
        add_key(9'h003, 8'h74); add_key(9'h00B, 8'h75); add_key(9'h00A, 8'h76); add_key(9'h001, 8'h77);
        add_key(9'h05D, 8'h78); add_key(9'h174, 8'h79);
        add_key(9'h070, 8'h27); add_key(9'h069, 8'h30); add_key(9'h072, 8'h31); add_key(9'h07A, 8'h11);
        add_key(9'h06B, 8'h12); add_key(9'h073, 8'h13); add_key(9'h074, 8'h34); add_key(9'h06C, 8'h24);
        add_key(9'h075, 8'h15); add_key(9'h07D, 8'h26); add_key(9'h071, 8'h67); add_key(9'h07B, 8'h17);
        pool.push_back(7);  // F12 = Break
    endfunction

    function automatic void m_clear_all();
        m_keys = '0;
        m_brk  = 1'b0;
    endfunction

    function automatic void m_complete(input bit ext, input bit brk, input logic [7:0] code);
        int k;
        k = (ext ? 256 : 0) + int'(code);
        m_pending.delete();
        if (k == 7) m_brk = !brk;
        else if (key_bit.exists(k)) m_keys[key_bit[k]] = !brk;
        else m_unm = 1'b1;
    endfunction

    function automatic void m_byte(input logic [7:0] d, input bit e);
        if (e) begin
            m_pending.delete();
            m_clear_all();
        end else if (m_pending.size() > 0 && m_pending[0] == 8'hE1) begin
            // Pause: the E1 plus seven further bytes carry nothing
            m_pending.push_back(d);
            if (m_pending.size() == 8) m_pending.delete();
        end else if (m_pending.size() == 0) begin
            if (d == 8'hE0 || d == 8'hF0 || d == 8'hE1) m_pending.push_back(d);
            else if (d == 8'hAA) m_clear_all();
            else if (d == 8'h00 || d == 8'hFA || d == 8'hFC || d == 8'hFE || d == 8'hFF) begin
            end else m_complete(1'b0, 1'b0, d);
        end else if (m_pending.size() == 1 && m_pending[0] == 8'hE0) begin
            if (d == 8'hF0) m_pending.push_back(d);
            else if (d == 8'h12 || d == 8'h7C) m_pending.delete();
            else m_complete(1'b1, 1'b0, d);
        end else begin
            m_complete(m_pending[0] == 8'hE0, 1'b1, d);
        end
    endfunction

    function automatic logic [79:0] m_expected();
        logic [79:0] e;
        e = m_keys;
        for (int c = 2; c < 10; c++) e[c*8] = m_dip[c-2];
        return e;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [79:0] e;
        e = m_expected();
        chk({tag, " c0_7"}, 80'(bbc_keyboard__keys_down_cols_0_to_7), 80'(e[63:0]));
        chk({tag, " c8_9"}, 80'(bbc_keyboard__keys_down_cols_8_to_9), 80'(e[79:64]));
        chk({tag, " brk"},  80'(bbc_keyboard__reset_pressed), 80'(m_brk));
        chk({tag, " unm"},  80'(unmapped_key), 80'(m_unm));
    endtask

    // ---------------- stimulus ----------------
    task automatic send(input logic [7:0] d, input bit e = 1'b0);
        ps2_rx__valid = 1'b1;
        ps2_rx__data  = d;
        ps2_rx__error = e;
        @(posedge clk);
        #1;
        ps2_rx__valid = 1'b0;
        ps2_rx__error = 1'b0;
        if (m_gap >= TMO) m_pending.delete();
        m_gap = 0;
        m_unm = 1'b0;
        m_dip = dip_switches;
        m_byte(d, e);
        n_txn++;
        $display("txn %0d: byte=%02h err=%0b -> c0_7=%016h c8_9=%04h brk=%0b unm=%0b",
                 n_txn, d, e, bbc_keyboard__keys_down_cols_0_to_7,
                 bbc_keyboard__keys_down_cols_8_to_9, bbc_keyboard__reset_pressed, unmapped_key);
        check_model($sformatf("txn%0d", n_txn));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            ps2_rx__valid = 1'b0;
            @(posedge clk);
            #1;
            m_gap++;
            m_unm = 1'b0;
            m_dip = dip_switches;
            check_model("idle");
        end
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        ps2_rx__valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        m_clear_all();
        m_unm = 1'b0;
        m_pending.delete();
        m_gap = 0;
        m_dip = 8'h00;
        check_model("reset");
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int sc;
        bit brk;

        reset         = 1'b1;
        ps2_rx__valid = 1'b0;
        ps2_rx__data  = 8'h00;
        ps2_rx__error = 1'b0;
        dip_switches  = 8'h00;
        m_gap         = 0;
        build_table();

        do_reset();
        chk("reset_c0_7", 80'(bbc_keyboard__keys_down_cols_0_to_7), 80'h0);

        // A make / break
        send(8'h1C);
        chk("A_make", 80'(bbc_keyboard__keys_down_cols_0_to_7), 80'h0000_0000_0000_1000);
        send(8'hF0); send(8'h1C);
        chk("A_break", 80'(bbc_keyboard__keys_down_cols_0_to_7), 80'h0);

        // Right arrow (extended) vs keypad 6
        send(8'hE0); send(8'h74);
        chk("rarrow_make", 80'(bbc_keyboard__keys_down_cols_8_to_9), 80'h8000);
        send(8'hE0); send(8'hF0); send(8'h74);
        chk("rarrow_break", 80'(bbc_keyboard__keys_down_cols_8_to_9), 80'h0);
        send(8'h74);
        chk("kp6_not_col9", 80'(bbc_keyboard__keys_down_cols_8_to_9), 80'h0);
        send(8'hF0); send(8'h74);

        // F12 = Break
        send(8'h07);
        chk("f12_make", 80'(bbc_keyboard__reset_pressed), 80'h1);
        chk("f12_matrix", 80'(bbc_keyboard__keys_down_cols_0_to_7), 80'h0);
        send(8'hF0); send(8'h07);
        chk("f12_break", 80'(bbc_keyboard__reset_pressed), 80'h0);

        // Several keys then an rx error
        send(8'h15); send(8'h29); send(8'h76);
        chk("q_sp_esc", 80'(bbc_keyboard__keys_down_cols_0_to_7), 80'h0000_0000_0040_0082);
        send(8'h07);
        send(8'h00, 1'b1);
        chk("err_clear", 80'(bbc_keyboard__keys_down_cols_0_to_7), 80'h0);
        chk("err_brk", 80'(bbc_keyboard__reset_pressed), 80'h0);

        // Pause sequence is swallowed
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        chk("pause_none", 80'(bbc_keyboard__keys_down_cols_0_to_7), 80'h0);
        send(8'h1C);
        chk("after_pause", 80'(bbc_keyboard__keys_down_cols_0_to_7), 80'h0000_0000_0000_1000);

        // Dangling F0 times out; just inside the limit it still completes
        send(8'hF0); idle(20); send(8'h1C);
        chk("timeout_make", 80'(bbc_keyboard__keys_down_cols_0_to_7), 80'h0000_0000_0000_1000);
        send(8'hF0); idle(TMO - 1); send(8'h1C);
        chk("pre_timeout_brk", 80'(bbc_keyboard__keys_down_cols_0_to_7), 80'h0);
        send(8'hF0); idle(TMO); send(8'h1C);
        send(8'hF0); send(8'h1C);

        // Unmapped and fake-shift
        send(8'h11);
        chk("unmapped_pulse", 80'(unmapped_key), 80'h1);
        idle(1);
        send(8'hE0); send(8'h12);
        chk("fake_shift", 80'(unmapped_key), 80'h0);
        send(8'hF0); send(8'h11);

        // Typematic, shift/ctrl aliasing, BAT
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
        send(8'h12); send(8'h59); send(8'hF0); send(8'h59);
        chk("shift_alias", 80'(bbc_keyboard__keys_down_cols_0_to_7), 80'h0);
        send(8'h14); send(8'hE0); send(8'h14); send(8'hE0); send(8'hF0); send(8'h14);
        chk("ctrl_alias", 80'(bbc_keyboard__keys_down_cols_0_to_7), 80'h0);
        send(8'h1C); send(8'hAA);
        chk("bat_clear", 80'(bbc_keyboard__keys_down_cols_0_to_7), 80'h0);

        // DIP links on row 0 of columns 2-9
        dip_switches = 8'hA5;
        idle(2);
        chk("dip_c0_7", 80'(bbc_keyboard__keys_down_cols_0_to_7), 80'h0100_0001_0001_0000);
        chk("dip_c8_9", 80'(bbc_keyboard__keys_down_cols_8_to_9), 80'h0100);
        send(8'h12);
        chk("dip_shift", 80'(bbc_keyboard__keys_down_cols_0_to_7), 80'h0100_0001_0001_0001);

        // Reset in the middle of an E0 sequence
        send(8'hE0);
        do_reset();
        send(8'h74);
        chk("rst_mid_seq", 80'(bbc_keyboard__keys_down_cols_8_to_9), 80'h0100);
        dip_switches = 8'h00;
        send(8'hF0); send(8'h74);

        // Randomized streams
        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 99);
            if (it == 150) dip_switches = 8'($urandom());
            if (r < 3) begin
                send(8'($urandom()), 1'b1);
            end else if (r < 5) begin
                send(8'hAA);
            end else if (r < 8) begin
                send(8'hE1);
                for (int j = 0; j < 7; j++) begin
                    send(8'($urandom()));
                    idle($urandom_range(0, 2));
                end
            end else if (r < 10) begin
                sc = $urandom_range(0, 4);
                send(sc == 0 ? 8'h00 : sc == 1 ? 8'hFA : sc == 2 ? 8'hFC : sc == 3 ? 8'hFE : 8'hFF);
            end else if (r < 13) begin
                send(8'hE0);
                send(r < 12 ? 8'h12 : 8'h7C);
            end else if (r < 16) begin
                send(r < 15 ? 8'hF0 : 8'hE0);
                idle($urandom_range(TMO - 2, TMO + 2));
            end else begin
                if (r < 22) sc = $urandom_range(0, 511);
                else sc = pool[$urandom_range(0, pool.size() - 1)];
                brk = ($urandom_range(0, 1) == 1);
                if (((sc >> 8) & 1) == 1) begin
                    send(8'hE0);
                    idle($urandom_range(0, 1));
                end
                if (brk) begin
                    send(8'hF0);
                    idle($urandom_range(0, 1));
                end
                send(8'(sc));
            end
            idle($urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
